// File: rtl/snake_engine.sv
// Snake game engine: tick-paced movement, direction filtering, edge
// wrap/wall handling, food growth and self-collision detection.
module snake_engine #(
  parameter int GRID_W   = 8,
  parameter int GRID_H   = 8,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int TICK_CNT = 10000000,
  parameter int WRAP_EN  = 1,
  localparam int CW      = $clog2(GRID_W * GRID_H),
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    snake_en,
  input  logic [3:0]              dir_key,
  input  logic [CW-1:0]           food_pos,
  input  logic                    food_valid,
  output logic [MAX_LEN*CW-1:0]   snake_body,
  output logic [LW-1:0]           snake_len,
  output logic [1:0]              state,
  output logic                    move,
  output logic                    food_eaten
);

  localparam int CNTW  = $clog2(TICK_CNT);
  localparam int HEAD0 = (GRID_H / 2) * GRID_W + GRID_W / 2;

  localparam logic [CW-1:0]   C_ONE  = CW'(1);
  localparam logic [CW-1:0]   C_W    = CW'(GRID_W);
  localparam logic [CW-1:0]   C_WM1  = CW'(GRID_W - 1);
  localparam logic [CW-1:0]   C_HM1  = CW'(GRID_H - 1);
  localparam logic [CNTW-1:0] C_LAST = CNTW'(TICK_CNT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DIE = 2'd2} state_t;
  // Encoding chosen so that the reverse direction is dir ^ 1.
  typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  dir_t            dir_q, dir_d;   // latched, waiting for the next step
  dir_t            app_q, app_d;   // last direction actually applied
  logic [LW-1:0]   len_q, len_d;
  logic [CW-1:0]   seg_q [MAX_LEN];
  logic [CW-1:0]   seg_d [MAX_LEN];
  logic [CW-1:0]   init_seg [MAX_LEN];

  logic            key_ok;
  dir_t            key_dir;
  dir_t            eff_dir;
  logic [CW-1:0]   row, col, nrow, ncol, new_head;
  logic            edge_cross, wall_hit, grow, hit, step_ok;
  int              lim;

  // Starting body: horizontal run to the right of the centre cell, rest zero.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_init
      assign init_seg[gi] = (gi < INIT_LEN) ? CW'(HEAD0 + gi) : '0;
      assign snake_body[gi*CW +: CW] = seg_q[gi];
    end
  endgenerate

  assign snake_len = len_q;
  assign state     = state_q;
  assign move      = (state_q == RUN) && (cnt_q == C_LAST);

  // Key filter: accept a single one-hot key that does not reverse the applied direction.
  always_comb begin
    key_ok  = 1'b1;
    key_dir = D_LEFT;
    case (dir_key)
      4'b0001: key_dir = D_UP;
      4'b0010: key_dir = D_DOWN;
      4'b0100: key_dir = D_LEFT;
      4'b1000: key_dir = D_RIGHT;
      default: key_ok  = 1'b0;
    endcase
    if (key_ok && (key_dir == dir_t'(app_q ^ 2'b01))) key_ok = 1'b0;
  end

  // Next head position, edge handling, food match and self-collision.
  always_comb begin
    eff_dir    = key_ok ? key_dir : dir_q;
    row        = seg_q[0] / C_W;
    col        = seg_q[0] % C_W;
    nrow       = row;
    ncol       = col;
    edge_cross = 1'b0;
    case (eff_dir)
      D_UP:    if (row == '0)    begin edge_cross = 1'b1; nrow = C_HM1; end else nrow = row - C_ONE;
      D_DOWN:  if (row == C_HM1) begin edge_cross = 1'b1; nrow = '0;    end else nrow = row + C_ONE;
      D_LEFT:  if (col == '0)    begin edge_cross = 1'b1; ncol = C_WM1; end else ncol = col - C_ONE;
      default: if (col == C_WM1) begin edge_cross = 1'b1; ncol = '0;    end else ncol = col + C_ONE;
    endcase
    new_head = nrow * C_W + ncol;
    wall_hit = edge_cross && (WRAP_EN == 0);
    grow     = food_valid && (new_head == food_pos);
    // The tail cell vacates on a non-growing step, so it is excluded.
    lim      = int'(len_q) - (grow ? 0 : 1);
    hit      = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < lim) && (seg_q[i] == new_head)) hit = 1'b1;
    end
    step_ok    = move && !wall_hit && !hit;
    food_eaten = step_ok && grow;
  end

  // Game FSM, tick counter, body shift and re-initialisation on IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = key_ok ? key_dir : dir_q;
    app_d   = app_q;
    len_d   = len_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (snake_en) state_d = RUN;
      end
      RUN: begin
        cnt_d = move ? '0 : cnt_q + CNTW'(1);
        if (move) begin
          if (wall_hit || hit) begin
            state_d = DIE;
          end else begin
            app_d = eff_dir;
            if (grow && (len_q < LW'(MAX_LEN))) len_d = len_q + LW'(1);
            seg_d[0] = new_head;
            for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
            for (int i = 0; i < MAX_LEN; i++) begin
              if (i >= int'(len_d)) seg_d[i] = '0;
            end
          end
        end
      end
      default: cnt_d = '0;
    endcase
    if (!snake_en) state_d = IDLE;
    if (state_d == IDLE) begin
      cnt_d = '0;
      dir_d = D_LEFT;
      app_d = D_LEFT;
      len_d = LW'(INIT_LEN);
      seg_d = init_seg;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= D_LEFT;
      app_q   <= D_LEFT;
      len_q   <= LW'(INIT_LEN);
      seg_q   <= init_seg;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      app_q   <= app_d;
      len_q   <= len_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 8, grid columns (>=4).
REQ-002 SHALL have parameter GRID_H, default 8, grid rows (>=4).
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum segment count (>=INIT_LEN).
REQ-004 SHALL have parameter INIT_LEN, default 4, segment count after reset or restart (>=2).
REQ-005 SHALL have parameter TICK_CNT, default 10000000, sys_clk cycles per move step (>=2).
REQ-006 SHALL have parameter WRAP_EN, default 1: 1 = wrap at edges, 0 = wall hit kills.
REQ-007 SHALL derive CW = clog2(GRID_W*GRID_H), the cell index width; cell = row*GRID_W + col.
REQ-008 SHALL have port sys_clk, input, 1, the only clock.
REQ-009 SHALL have port sys_rst, input, 1, reset: one clock; reset is synchronous and active-high.
REQ-010 SHALL have port snake_en, input, 1, game enable level.
REQ-011 SHALL have port dir_key, input, 4, one-hot key pulse: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-012 SHALL have port food_pos, input, CW, food cell index.
REQ-013 SHALL have port food_valid, input, 1, food_pos valid.
REQ-014 SHALL have port snake_body, output, MAX_LEN*CW, segment i at bits [i*CW +: CW]; segment 0 is the head.
REQ-015 SHALL have port snake_len, output, clog2(MAX_LEN+1), live segment count.
REQ-016 SHALL have port state, output, 2, IDLE=0, RUN=1, DIE=2.
REQ-017 SHALL have port move, output, 1, one-cycle pulse on each step.
REQ-018 SHALL have port food_eaten, output, 1, one-cycle pulse coincident with move when food is eaten.

Function
REQ-019 SHALL clear the tick counter in IDLE and DIE; in RUN count 0..TICK_CNT-1 and assert move for the cycle the counter equals TICK_CNT-1, then wrap to 0.
REQ-020 SHALL latch a direction when dir_key has exactly one bit set and that direction is not the reverse of the direction last applied; reject all other keys.
REQ-021 SHALL apply the latched direction only at a move step; a key arriving in the same cycle as move SHALL apply to that step.
REQ-022 SHALL on each step compute the new head: up row-1, down row+1, left col-1, right col+1.
REQ-023 SHALL, with WRAP_EN=1, wrap row 0 -> GRID_H-1, row GRID_H-1 -> 0, col 0 -> GRID_W-1 and col GRID_W-1 -> 0 within the same row/column; with WRAP_EN=0 an edge crossing SHALL go to DIE with body unchanged.
REQ-024 SHALL define grow = food_valid and new head == food_pos.
REQ-025 SHALL shift segments: seg[i] <= seg[i-1] for i>=1, seg[0] <= new head; if grow and snake_len<MAX_LEN then snake_len+1; otherwise the length is unchanged.
REQ-026 SHALL pulse food_eaten on grow, including when snake_len is saturated at MAX_LEN.
REQ-027 SHALL detect self-collision when the new head equals seg[0..snake_len-2] (no grow) or seg[0..snake_len-1] (grow); collision SHALL go to DIE with body and length unchanged and no food_eaten.
REQ-028 SHALL hold segments at index >= snake_len at 0.
REQ-029 SHALL make state transitions: IDLE->RUN when snake_en=1; RUN->DIE on collision or wall; any state->IDLE when snake_en=0; DIE is held while snake_en=1.
REQ-030 SHALL on entry to IDLE reinitialise the body, length and direction as at reset.

Reset
REQ-031 SHALL on sys_rst=1 at a sys_clk edge, including mid-game: state=IDLE, counter=0, move=0, food_eaten=0, direction=left, snake_len=INIT_LEN, head=(GRID_H/2)*GRID_W+GRID_W/2, seg[i]=head+i for i<INIT_LEN, all others 0.

Verification (GRID 8x8, INIT_LEN 4, TICK_CNT 4, MAX_LEN 16)
REQ-032 Reset, then snake_en=1 -> body {36,37,38,39}, len 4; move every 4 cycles; first step gives {35,36,37,38}.
REQ-033 Left from head 32, WRAP_EN=1 -> head 39; same step with WRAP_EN=0 -> state DIE, body frozen.
REQ-034 food_valid=1, food_pos=35 at first step -> food_eaten pulse, len 5, body {35,36,37,38,39}.
REQ-035 Moving left, dir_key=right -> ignored; dir_key=0101 -> ignored; dir_key=up -> next head = head-8.
REQ-036 Len 5, keys up, right, down on consecutive steps -> head lands on seg[3] -> DIE; snake_en=0 -> IDLE with the reset body.
REQ-037 sys_rst pulsed mid-RUN -> all outputs at reset values on the next cycle.
